// File: rtl/peri_bus_bridge.sv
// peri_bus_bridge: single-outstanding core-to-peripheral bus initiator
// with address decode, one-hot selects and per-access watchdog.
package peri_bus_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  sel_byte;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

endpackage

module peri_bus_bridge
  import peri_bus_pkg::*;
#(
  parameter logic [31:0] GPIOA_BASE = 32'h9000_0000,
  parameter logic [31:0] GPIOB_BASE = 32'h9000_0100,
  parameter logic [31:0] GPIOC_BASE = 32'h9000_0200,
  parameter logic [31:0] GPSW_BASE  = 32'h9000_0300,
  parameter logic [31:0] GPLED_BASE = 32'h9000_0400,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [31:0]     req_addr_i,
  input  logic [31:0]     req_wdata_i,
  input  logic            req_we_i,
  input  logic [3:0]      req_be_i,
  output logic            rsp_valid_o,
  output logic [31:0]     rsp_rdata_o,
  output logic            rsp_err_o,
  output type_dbus2peri_s dbus2peri_o,
  input  type_peri2dbus_s peri2dbus_i,
  output logic            gpioA_sel_o,
  output logic            gpioB_sel_o,
  output logic            gpioC_sel_o,
  output logic            gpsw_sel_o,
  output logic            gpled_sel_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TO =
    CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [4:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [4:0]       dec_sel;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_access;

  // Region decode on the upper 24 address bits; bit order {led,sw,c,b,a}
  always_comb begin
    dec_sel    = '0;
    dec_sel[0] = req_addr_i[31:8] == GPIOA_BASE[31:8];
    dec_sel[1] = req_addr_i[31:8] == GPIOB_BASE[31:8];
    dec_sel[2] = req_addr_i[31:8] == GPIOC_BASE[31:8];
    dec_sel[3] = req_addr_i[31:8] == GPSW_BASE[31:8];
    dec_sel[4] = req_addr_i[31:8] == GPLED_BASE[31:8];
  end

  // Saturating watchdog increment
  always_comb begin
    cnt_inc = (cnt_q == CNT_TO) ? cnt_q
                                : cnt_q + CNT_W'(1);
  end

  // Next-state and captured-response logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    be_d    = be_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          we_d    = req_we_i;
          be_d    = req_be_i;
          sel_d   = dec_sel;
          cnt_d   = '0;
          if (|dec_sel) begin
            state_d = ACCESS;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (peri2dbus_i.ack) begin
          state_d = RESP;
          rdata_d = we_q ? 32'h0
                         : peri2dbus_i.r_data;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_TO) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign in_access   = state_q == ACCESS;
  assign req_ready_o = rst_n && (state_q == IDLE);
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // Bus request and selects only driven during ACCESS
  always_comb begin
    dbus2peri_o = '0;
    if (in_access) begin
      dbus2peri_o.addr     = addr_q;
      dbus2peri_o.w_data   = wdata_q;
      dbus2peri_o.sel_byte = be_q;
      dbus2peri_o.w_en     = we_q;
      dbus2peri_o.req      = 1'b1;
    end
  end

  assign gpioA_sel_o = in_access & sel_q[0];
  assign gpioB_sel_o = in_access & sel_q[1];
  assign gpioC_sel_o = in_access & sel_q[2];
  assign gpsw_sel_o  = in_access & sel_q[3];
  assign gpled_sel_o = in_access & sel_q[4];

endmodule

// File: tb/tb_peri_bus_bridge.sv
// tb_peri_bus_bridge: directed vector bench for peri_bus_bridge
// with TIMEOUT_CYCLES=4, plus reset and back-to-back sequences.
module tb_peri_bus_bridge;
  import peri_bus_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            req_we;
  logic [3:0]      req_be;
  logic            rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  type_dbus2peri_s dbus;
  type_peri2dbus_s peri;
  logic            sa, sb, sc, ssw, sled;

  int n_chk;
  int n_pass;

  peri_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_we_i    (req_we),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .dbus2peri_o (dbus),
    .peri2dbus_i (peri),
    .gpioA_sel_o (sa),
    .gpioB_sel_o (sb),
    .gpioC_sel_o (sc),
    .gpsw_sel_o  (ssw),
    .gpled_sel_o (sled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    int          ack_cyc;
    logic [31:0] prd;
    logic [4:0]  sel;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [4:0] sels();
    return {sled, ssw, sc, sb, sa};
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int got;
    got = 0;
    @(negedge clk);
    check({v.name, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_we    = v.we;
    req_be    = v.be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      peri.ack    = (k == v.ack_cyc);
      peri.r_data = peri.ack ? v.prd : 32'hDEAD_BEEF;
      @(negedge clk);
      if (rsp_valid) begin
        got = k;
        check({v.name, " rdata"}, rsp_rdata, v.rdata);
        check({v.name, " err"}, 32'(rsp_err), 32'(v.err));
        check({v.name, " rsp bus idle"},
              {26'd0, dbus.req, sels()}, 32'd0);
        break;
      end
      check({v.name, " sel"}, 32'(sels()), 32'(v.sel));
      check({v.name, " req/we/be"},
            {26'd0, dbus.req, dbus.w_en, dbus.sel_byte},
            {26'd0, 1'b1, v.we, v.be});
      check({v.name, " addr"}, dbus.addr, v.addr);
      check({v.name, " wdata"}, dbus.w_data, v.wdata);
      @(posedge clk);
      #1;
    end
    peri.ack = 1'b0;
    check({v.name, " latency"}, 32'(got), 32'(v.lat));
  endtask

  initial begin
    int acc[$];
    int rsp[$];
    int twohot;
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_we    = 1'b0;
    req_be    = '0;
    peri      = '0;

    vecs[0] = '{"rd_b", 32'h9000_0104, 32'h0, 1'b0,
                4'hF, 2, 32'h0000_00A5, 5'b00010,
                3, 32'h0000_00A5, 1'b0};
    vecs[1] = '{"wr_led", 32'h9000_0400, 32'h0000_F00F,
                1'b1, 4'b0011, 1, 32'h1234_5678,
                5'b10000, 2, 32'h0, 1'b0};
    vecs[2] = '{"unmapped", 32'h8000_0000, 32'h0, 1'b0,
                4'hF, 1, 32'h5555_5555, 5'b00000,
                1, 32'h0, 1'b1};
    vecs[3] = '{"timeout", 32'h9000_0300, 32'h0, 1'b0,
                4'hF, 0, 32'h0, 5'b01000,
                5, 32'h0, 1'b1};
    vecs[4] = '{"ack_last", 32'h9000_00FC, 32'h0, 1'b0,
                4'hF, 4, 32'h1111_2222, 5'b00001,
                5, 32'h1111_2222, 1'b0};
    vecs[5] = '{"wr_c", 32'h9000_02FF, 32'hCAFE_0001,
                1'b1, 4'b1000, 3, 32'h9999_0000,
                5'b00100, 4, 32'h0, 1'b0};
    vecs[6] = '{"near_miss", 32'h9000_0500, 32'h0, 1'b0,
                4'hF, 1, 32'h0, 5'b00000,
                1, 32'h0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst rsp", {rsp_rdata[30:0], rsp_valid},
          32'd0);
    check("rst err", 32'(rsp_err), 32'd0);
    check("rst bus", {26'd0, dbus.req, sels()}, 32'd0);
    check("rst addr", dbus.addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post rst ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h9000_0108;
    req_we    = 1'b0;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mid rst c1 req", 32'(dbus.req), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid rst c2 sel", 32'(sels()), 32'b00010);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    peri.ack    = 1'b1;
    peri.r_data = 32'hBAD0_BAD0;
    @(negedge clk);
    check("mid rst bus", {24'd0, dbus.req, req_ready,
          rsp_valid, sels()}, 32'd0);
    check("mid rst addr", dbus.addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid rst no rsp", 32'(rsp_valid), 32'd0);
    check("mid rst ready", 32'(req_ready), 32'd1);
    peri = '0;
    begin
      vec_t va;
      va = '{"rd_a", 32'h9000_0010, 32'h0, 1'b0,
             4'hF, 1, 32'h0BAD_F00D, 5'b00001,
             2, 32'h0BAD_F00D, 1'b0};
      run_vec(va);
    end

    @(negedge clk);
    req_valid   = 1'b1;
    req_addr    = 32'h9000_0204;
    req_we      = 1'b0;
    req_be      = 4'hF;
    peri.ack    = 1'b1;
    peri.r_data = 32'h0000_0077;
    twohot      = 0;
    for (int n = 0; n < 6; n++) begin
      if (n > 0) @(negedge clk);
      if (req_ready) acc.push_back(n);
      if (rsp_valid) begin
        rsp.push_back(n);
        check("b2b rdata", rsp_rdata, 32'h77);
      end
      if ($countones(sels()) > 1) twohot++;
      if (n == 5) req_valid = 1'b0;
    end
    peri = '0;
    check("b2b accepts", 32'(acc.size()), 32'd2);
    check("b2b rsps", 32'(rsp.size()), 32'd2);
    if (acc.size() == 2 && rsp.size() == 2) begin
      check("b2b 2nd accept", 32'(acc[1]),
            32'(rsp[0] + 1));
      check("b2b 2nd rsp", 32'(rsp[1]), 32'd5);
    end else begin
      check("b2b counts", 32'(acc.size() * 16
            + rsp.size()), 32'h22);
    end
    check("b2b two-hot", 32'(twohot), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
